// File: rtl/boot_sequencer.sv
// Boot sequencer: streams data-memory then instruction-memory images from a
// valid/ready source, runs the CPU, and reports the halt code and cycle count.
//
//   state  | meaning
//   -------+--------------------------------------------------
//   IDLE   | waiting for start after reset
//   LOAD_D | accepting boot words into data memory
//   LOAD_I | accepting boot words into instruction memory
//   FLUSH  | final imem write drains, CPU not yet enabled
//   RUN    | CPU enabled, counting cycles, watching for halt
//   DONE   | halted; halt_code and cycle_count held
module boot_sequencer #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic [31:0] addr_ext,
    output logic [31:0] wdata_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] addr_ext_2,
    output logic [31:0] wdata_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic        enable,
    input  logic [31:0] instruction,
    output logic        busy,
    output logic        done,
    output logic [1:0]  halt_code,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {IDLE, LOAD_D, LOAD_I, FLUSH, RUN, DONE} state_t;

    localparam logic [31:0] D_LAST = 32'(DMEM_WORDS - 1);
    localparam logic [31:0] I_LAST = 32'(IMEM_WORDS - 1);

    state_t      state;
    logic [31:0] idx;
    logic        accept;
    logic        halt_seen;
    logic        unused_instr;

    assign s_ready      = (state == LOAD_D) || (state == LOAD_I);
    assign accept       = s_valid && s_ready;
    assign busy         = (state != IDLE) && (state != DONE);
    assign done         = (state == DONE);
    assign ren_ext      = 1'b0;
    assign ren_ext_2    = 1'b0;
    assign halt_seen    = (instruction[31:26] == 6'b111110);
    assign unused_instr = ^instruction[25:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            addr_ext    <= '0;
            wdata_ext   <= '0;
            wen_ext     <= 1'b0;
            addr_ext_2  <= '0;
            wdata_ext_2 <= '0;
            wen_ext_2   <= 1'b0;
            enable      <= 1'b0;
            halt_code   <= '0;
            cycle_count <= '0;
        end else begin
            // Write strobes are single-cycle pulses following each accepted word.
            wen_ext   <= 1'b0;
            wen_ext_2 <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= LOAD_D;
                        idx         <= '0;
                        cycle_count <= '0;
                        halt_code   <= '0;
                    end
                end
                LOAD_D: begin
                    if (accept) begin
                        wen_ext_2   <= 1'b1;
                        addr_ext_2  <= {idx[29:0], 2'b00};
                        wdata_ext_2 <= s_data;
                        if (idx == D_LAST) begin
                            idx   <= '0;
                            state <= LOAD_I;
                        end else begin
                            idx <= idx + 32'd1;
                        end
                    end
                end
                LOAD_I: begin
                    if (accept) begin
                        wen_ext   <= 1'b1;
                        addr_ext  <= {idx[29:0], 2'b00};
                        wdata_ext <= s_data;
                        if (idx == I_LAST) begin
                            idx   <= '0;
                            state <= FLUSH;
                        end else begin
                            idx <= idx + 32'd1;
                        end
                    end
                end
                FLUSH: begin
                    state  <= RUN;
                    enable <= 1'b1;
                end
                RUN: begin
                    if (halt_seen) begin
                        state     <= DONE;
                        enable    <= 1'b0;
                        halt_code <= instruction[1:0];
                    end else if (cycle_count != 32'hFFFF_FFFF) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer with small memories (8 dmem, 4 imem words).
module tb_boot_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic        enable;
    logic [31:0] instruction = '0;
    logic        busy, done;
    logic [1:0]  halt_code;
    logic [31:0] cycle_count;

    int vectors = 0;
    int miscompares = 0;
    int wr_count;

    boot_sequencer #(.IMEM_WORDS(4), .DMEM_WORDS(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .addr_ext(addr_ext), .wdata_ext(wdata_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .addr_ext_2(addr_ext_2), .wdata_ext_2(wdata_ext_2), .wen_ext_2(wen_ext_2),
        .ren_ext_2(ren_ext_2), .enable(enable), .instruction(instruction),
        .busy(busy), .done(done), .halt_code(halt_code), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".s_ready"}, 32'(s_ready), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".enable"}, 32'(enable), 0);
        chk({tag, ".wen"}, 32'(wen_ext), 0);
        chk({tag, ".wen2"}, 32'(wen_ext_2), 0);
        chk({tag, ".addr"}, addr_ext, 0);
        chk({tag, ".addr2"}, addr_ext_2, 0);
        chk({tag, ".wdata"}, wdata_ext, 0);
        chk({tag, ".wdata2"}, wdata_ext_2, 0);
        chk({tag, ".halt_code"}, 32'(halt_code), 0);
        chk({tag, ".cycle_count"}, cycle_count, 0);
        chk({tag, ".ren"}, 32'({ren_ext, ren_ext_2}), 0);
    endtask

    initial begin
        // Reset for two cycles, then idle with start low.
        rst = 1'b1;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (3) step();
        chk("idle.busy", 32'(busy), 0);
        chk("idle.s_ready", 32'(s_ready), 0);

        // Back-to-back load.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start.busy", 32'(busy), 1);
        chk("start.s_ready", 32'(s_ready), 1);
        chk("start.wen2", 32'(wen_ext_2), 0);
        s_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_data = 32'h100 + 32'(k);
            step();
            chk("b2b.wen2", 32'(wen_ext_2), 1);
            chk("b2b.addr2", addr_ext_2, 32'(k * 4));
            chk("b2b.wdata2", wdata_ext_2, 32'h100 + 32'(k));
            chk("b2b.wen_d", 32'(wen_ext), 0);
        end
        for (int k = 0; k < 4; k++) begin
            s_data = 32'h100 + 32'(k);
            step();
            chk("b2b.wen", 32'(wen_ext), 1);
            chk("b2b.addr", addr_ext, 32'(k * 4));
            chk("b2b.wdata", wdata_ext, 32'h100 + 32'(k));
            chk("b2b.wen2_i", 32'(wen_ext_2), 0);
            chk("b2b.enable_i", 32'(enable), 0);
        end
        s_valid = 1'b0;
        chk("flush.s_ready", 32'(s_ready), 0);
        chk("flush.busy", 32'(busy), 1);
        step();
        chk("run.enable", 32'(enable), 1);
        chk("run.wen", 32'(wen_ext), 0);
        chk("run.count0", cycle_count, 0);

        // 37 non-halting run cycles, with a start pulse that must be ignored.
        for (int c = 0; c < 37; c++) begin
            start = (c == 10);
            step();
            start = 1'b0;
            if (c == 10) begin
                chk("run_start.enable", 32'(enable), 1);
                chk("run_start.s_ready", 32'(s_ready), 0);
                chk("run_start.count", cycle_count, 11);
            end
        end
        chk("run.count37", cycle_count, 37);
        instruction = 32'hF800_0001;
        step();
        instruction = 32'h0;
        chk("halt.enable", 32'(enable), 0);
        chk("halt.done", 32'(done), 1);
        chk("halt.busy", 32'(busy), 0);
        chk("halt.code", 32'(halt_code), 1);
        chk("halt.count", cycle_count, 37);
        repeat (3) step();
        chk("done_hold.done", 32'(done), 1);
        chk("done_hold.code", 32'(halt_code), 1);
        chk("done_hold.count", cycle_count, 37);

        // Start from DONE, then load dmem with bubbles.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart.done", 32'(done), 0);
        chk("restart.count", cycle_count, 0);
        chk("restart.code", 32'(halt_code), 0);
        chk("restart.busy", 32'(busy), 1);
        wr_count = 0;
        for (int j = 0; j < 16; j++) begin
            s_valid = (j % 2 == 0);
            s_data  = 32'h200 + 32'(j / 2);
            step();
            if (wen_ext_2) wr_count++;
            chk("bub.wen2", 32'(wen_ext_2), 32'(j % 2 == 0));
            if (j % 2 == 0) begin
                chk("bub.addr2", addr_ext_2, 32'((j / 2) * 4));
                chk("bub.wdata2", wdata_ext_2, 32'h200 + 32'(j / 2));
            end
        end
        chk("bub.words", 32'(wr_count), 8);
        chk("bub.in_load_i", 32'(s_ready), 1);
        chk("bub.wen", 32'(wen_ext), 0);

        // Reset after imem word 2, with a word offered in the reset cycle.
        s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_data = 32'h300 + 32'(k);
            step();
            chk("mid.wen", 32'(wen_ext), 1);
            chk("mid.addr", addr_ext, 32'(k * 4));
        end
        s_data = 32'h303;
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_valid = 1'b0;
        chk_all_zero("mid_rst");
        step();
        chk("mid_rst.idle", 32'(busy), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        s_valid = 1'b1;
        s_data = 32'h400;
        step();
        s_valid = 1'b0;
        chk("reload.wen2", 32'(wen_ext_2), 1);
        chk("reload.addr2", addr_ext_2, 0);
        chk("reload.wdata2", wdata_ext_2, 32'h400);
        chk("reload.wen", 32'(wen_ext), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 The block SHALL have parameter IMEM_WORDS, default 512, giving the instruction-memory words to load.
REQ-002 The block SHALL have parameter DMEM_WORDS, default 1024, giving the data-memory words to load.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, a request to begin a load-and-run sequence.
REQ-006 The block SHALL have port s_valid, input, 1, meaning a boot word is present.
REQ-007 The block SHALL have port s_data, input, 32, the boot word.
REQ-008 The block SHALL have port s_ready, output, 1, meaning the block accepts a word.
REQ-009 The block SHALL have ports addr_ext/wdata_ext (output, 32) and wen_ext/ren_ext (output, 1) as the instruction-memory write port.
REQ-010 The block SHALL have ports addr_ext_2/wdata_ext_2 (output, 32) and wen_ext_2/ren_ext_2 (output, 1) as the data-memory write port.
REQ-011 The block SHALL have port enable, output, 1, the CPU run enable.
REQ-012 The block SHALL have port instruction, input, 32, the CPU's current instruction.
REQ-013 The block SHALL have port busy, output, 1, high in any state except IDLE or DONE.
REQ-014 The block SHALL have port done, output, 1, high in DONE.
REQ-015 The block SHALL have port halt_code, output, 2, the captured stop-instruction bits [1:0].
REQ-016 The block SHALL have port cycle_count, output, 32, the number of run cycles.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD_D, LOAD_I, FLUSH, RUN and DONE.
REQ-018 From IDLE or DONE, start=1 SHALL move the FSM to LOAD_D next cycle and clear cycle_count and halt_code to 0; start SHALL be ignored in all other states.
REQ-019 s_ready SHALL be 1 only in LOAD_D and LOAD_I; a word is accepted when s_valid and s_ready are both 1.
REQ-020 In LOAD_D, a word accepted with index k (starting at 0) at cycle t SHALL produce, at t+1 for exactly one cycle, wen_ext_2=1, addr_ext_2=k<<2 and wdata_ext_2=s_data; the port SHALL otherwise hold wen_ext_2=0.
REQ-021 In LOAD_I, accepted words SHALL be written the same way on wen_ext/addr_ext/wdata_ext, with the index restarting at 0.
REQ-022 When s_valid=0, the block SHALL issue no write and SHALL not advance the index, so addresses stay contiguous across bubbles.
REQ-023 Acceptance of word DMEM_WORDS-1 SHALL move the FSM to LOAD_I next cycle; acceptance of word IMEM_WORDS-1 SHALL move it to FLUSH.
REQ-024 FLUSH SHALL last exactly one cycle, during which the final imem write occurs, and SHALL then move to RUN.
REQ-025 ren_ext and ren_ext_2 SHALL be constant 0.
REQ-026 enable SHALL be registered and SHALL be 1 exactly while the FSM is in RUN.
REQ-027 In RUN, a halt SHALL be detected when instruction[31:26]==6'b111110.
REQ-028 In RUN without a halt, cycle_count SHALL increment by 1 per cycle and SHALL saturate at 32'hFFFFFFFF.
REQ-029 On halt detection, the FSM SHALL move to DONE next cycle, capture instruction[1:0] into halt_code, leave cycle_count unchanged, and drive enable=0 and done=1.
REQ-030 In DONE, done, halt_code and cycle_count SHALL hold until start or rst.

Reset
REQ-031 With rst=1 at a rising edge, the FSM SHALL enter IDLE and every output and internal index SHALL become 0, overriding start, s_valid and any in-progress load or run.
REQ-032 A write pending from a word accepted in the reset cycle SHALL be discarded.

Verification
REQ-033 Reset: assert rst for 2 cycles -> all outputs 0 and s_ready=0; with start=0 the block stays in IDLE.
REQ-034 Back-to-back load (DMEM_WORDS=8, IMEM_WORDS=4, s_data=index+0x100, s_valid=1): wen_ext_2 writes addr 0..28 on consecutive cycles, then wen_ext writes addr 0..12; enable=1 on the cycle after the last imem write.
REQ-035 Bubbles: s_valid alternates 1/0 during LOAD_D -> writes occur on alternate cycles, addresses stay contiguous, and the total word count is unchanged.
REQ-036 Halt: after 37 non-halting RUN cycles, drive instruction=32'hF8000001 -> next cycle enable=0, done=1, halt_code=2'b01, cycle_count=37.
REQ-037 Reset in the middle of LOAD_I (after imem word 2) -> next cycle IDLE with all outputs 0; a new start reloads from data-memory addr 0.
REQ-038 Start handling: start pulsed during RUN -> no effect; start pulsed in DONE -> LOAD_D next cycle, with done=0 and cycle_count=0.
